// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl -- power-up and soft-reset sequencer for the VGA frame converter.
//
// Startup waits for the clock enable, then waits for a qualified PLL lock. It
// holds every domain reset and then releases them one stage at a time: core,
// then frame buffer, then output timing. Loss of lock sends the sequencer back
// to waiting for lock. A register-requested soft reset re-runs the hold and
// release sequence from RUN. Every output is a flop in the pck domain.
//
// Compile-time option:
//   SOFT_VSYNC_ALIGN_EN  defined   : a soft reset fires on a rising edge of vsync.
//                        undefined : a soft reset fires on the cycle after it is
//                                    accepted, and vsync is ignored.
//
// Ports:
//   pck        in   pixel clock (only clock)
//   rst        in   synchronous active-high reset
//   cken       in   sequencer enable (level); low sends every state to IDLE
//   pll_lock   in   PLL lock, already synchronous to pck
//   vsync      in   frame sync from the output timing, active-high
//   soft_req   in   soft reset request (level), held until soft_ack
//   soft_ack   out  one-cycle pulse when a soft reset is taken
//   rstb_core  out  core reset, active-low
//   rstb_frame out  frame-buffer reset, active-low
//   rstb_out   out  output-timing reset, active-low
//   lock_err   out  sticky lock-timeout flag, cleared only by rst
//   seq_state  out  current state (IDLE=0 .. ERR=7)
//
// Handshake: soft_req is a level that the requester holds. The sequencer takes
// it only in RUN and answers with a single-cycle soft_ack on the edge that
// asserts the resets. The requester drops soft_req after it sees soft_ack.
// A request that is still high on the next return to RUN is taken again.

module rst_seq_ctrl #(
    parameter int ASSERT_CYC   = 16,
    parameter int STAGE_GAP    = 8,
    parameter int LOCK_TIMEOUT = 1000,
    parameter int LOCK_QUAL    = 4
) (
    input  logic       pck,
    input  logic       rst,
    input  logic       cken,
    input  logic       pll_lock,
    input  logic       vsync,
    input  logic       soft_req,
    output logic       soft_ack,
    output logic       rstb_core,
    output logic       rstb_frame,
    output logic       rstb_out,
    output logic       lock_err,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        HOLD      = 3'd2,
        REL_CORE  = 3'd3,
        REL_FRAME = 3'd4,
        RUN       = 3'd5,
        SOFT      = 3'd6,
        ERR       = 3'd7
    } state_t;

    // Terminal counts. A state that lasts N cycles leaves when cnt == N-1,
    // because cnt is 0 on the first cycle spent in that state.
    localparam logic [9:0] HOLD_LAST    = 10'(ASSERT_CYC - 1);
    localparam logic [9:0] GAP_LAST     = 10'(STAGE_GAP - 1);
    localparam logic [9:0] TIMEOUT_LAST = 10'(LOCK_TIMEOUT - 1);
    localparam logic [3:0] QUAL_LAST    = 4'(LOCK_QUAL - 1);

    state_t     state, state_n;
    logic [9:0] cnt, cnt_n;
    logic [3:0] qcnt, qcnt_n;
    logic       soft_ack_n;
    logic       trigger;

`ifdef SOFT_VSYNC_ALIGN_EN
    logic vsync_q;

    always_ff @(posedge pck) begin
        if (rst) vsync_q <= 1'b0;
        else     vsync_q <= vsync;
    end

    // A vsync that is already high when SOFT is entered gives no edge here.
    // It must fall and rise again before the soft reset fires.
    assign trigger = vsync & ~vsync_q;
`else
    logic unused_vsync;

    assign unused_vsync = vsync;
    assign trigger      = 1'b1;
`endif

    always_comb begin
        state_n    = state;
        cnt_n      = '0;
        qcnt_n     = '0;
        soft_ack_n = 1'b0;

        if (state != IDLE && !cken) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: state_n = WAIT_LOCK;
                WAIT_LOCK: begin
                    qcnt_n = pll_lock ? qcnt + 4'd1 : 4'd0;
                    // A lock that qualifies on the last timeout cycle still wins.
                    if (pll_lock && qcnt == QUAL_LAST) state_n = HOLD;
                    else if (cnt == TIMEOUT_LAST)      state_n = ERR;
                end
                HOLD: if (cnt == HOLD_LAST) state_n = REL_CORE;
                REL_CORE: begin
                    if (!pll_lock)            state_n = WAIT_LOCK;
                    else if (cnt == GAP_LAST) state_n = REL_FRAME;
                end
                REL_FRAME: begin
                    if (!pll_lock)            state_n = WAIT_LOCK;
                    else if (cnt == GAP_LAST) state_n = RUN;
                end
                RUN: begin
                    if (!pll_lock)     state_n = WAIT_LOCK;
                    else if (soft_req) state_n = SOFT;
                end
                SOFT: begin
                    // Losing lock abandons the soft reset without acking it,
                    // so the request is still pending on the next pass through RUN.
                    if (!pll_lock) begin
                        state_n = WAIT_LOCK;
                    end else if (trigger) begin
                        state_n    = HOLD;
                        soft_ack_n = 1'b1;
                    end
                end
                default: state_n = state;  // ERR: leaves only on cken=0 or rst
            endcase
        end

        // The cycle counter runs only in the timed states and restarts on
        // every state change.
        if (state_n == state &&
            (state == WAIT_LOCK || state == HOLD ||
             state == REL_CORE  || state == REL_FRAME))
            cnt_n = cnt + 10'd1;
        if (state_n != WAIT_LOCK)
            qcnt_n = '0;
    end

    // The reset outputs are decoded from the next state, so each release or
    // assertion appears on the same edge as the state change that causes it.
    always_ff @(posedge pck) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            qcnt       <= '0;
            soft_ack   <= 1'b0;
            rstb_core  <= 1'b0;
            rstb_frame <= 1'b0;
            rstb_out   <= 1'b0;
            lock_err   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            qcnt       <= qcnt_n;
            soft_ack   <= soft_ack_n;
            rstb_core  <= (state_n == REL_CORE) || (state_n == REL_FRAME) ||
                          (state_n == RUN)      || (state_n == SOFT);
            rstb_frame <= (state_n == REL_FRAME) || (state_n == RUN) ||
                          (state_n == SOFT);
            rstb_out   <= (state_n == RUN) || (state_n == SOFT);
            lock_err   <= lock_err | (state_n == ERR);
        end
    end

    assign seq_state = state;

endmodule
